// File: rtl/sirv_tl_frag_ctrl.sv
// Fragmenting sequencer for sirv_repeater_6: splits one TL-UL A request into 2^FRAG_SIZE-byte
// beats via the repeater's rpt input and merges the per-fragment D responses into one.
//   state   | meaning
//   S_IDLE  | no request; capture size/source of a presented beat
//   S_ISSUE | emitting fragments, responses may already return
//   S_WAIT  | all fragments issued, collecting remaining responses
module sirv_tl_frag_ctrl #(
  parameter int ADDR_W    = 30,
  parameter int SRC_W     = 2,
  parameter int MAX_SIZE  = 3,
  parameter int FRAG_SIZE = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  output logic              rpt_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        in_size_i,
  input  logic [SRC_W-1:0]  in_source_i,
  input  logic [ADDR_W-1:0] in_address_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [2:0]        out_size_o,
  output logic [ADDR_W-1:0] out_address_o,
  input  logic              d_in_valid_i,
  output logic              d_in_ready_o,
  input  logic              d_in_error_i,
  output logic              d_out_valid_o,
  input  logic              d_out_ready_i,
  output logic [2:0]        d_out_size_o,
  output logic [SRC_W-1:0]  d_out_source_o,
  output logic              d_out_error_o
);

  localparam int CNT_W = MAX_SIZE - FRAG_SIZE + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [2:0]        size_q, size_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [CNT_W-1:0]  icnt_q, icnt_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  last_idx;
  logic              ilast, rlast;
  logic              a_fire, d_final_fire;
  logic [2:0]        frag_size;
  logic [ADDR_W-1:0] frag_addr;

  // nfrag-1 is a run of (size-FRAG_SIZE) ones; zero when the request fits one fragment
  always_comb begin
    last_idx = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if ((int'(size_q) - FRAG_SIZE) > i) last_idx[i] = 1'b1;
    end
  end

  assign ilast     = (icnt_q == last_idx);
  assign rlast     = (rcnt_q == last_idx);
  assign frag_size = (in_size_i > 3'(FRAG_SIZE)) ? 3'(FRAG_SIZE) : in_size_i;
  assign frag_addr = in_address_i | (ADDR_W'(icnt_q) << FRAG_SIZE);
  assign a_fire    = in_valid_i & out_ready_i;

  assign d_out_size_o   = size_q;
  assign d_out_source_o = src_q;

  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    src_d         = src_q;
    icnt_d        = icnt_q;
    rcnt_d        = rcnt_q;
    err_d         = err_q;
    rpt_o         = 1'b0;
    in_ready_o    = 1'b0;
    out_valid_o   = 1'b0;
    out_size_o    = '0;
    out_address_o = '0;
    d_in_ready_o  = 1'b0;
    d_out_valid_o = 1'b0;
    d_out_error_o = 1'b0;
    d_final_fire  = 1'b0;

    // Non-final responses are swallowed; only the last one reaches the originator
    if (state_q != S_IDLE) begin
      d_out_error_o = err_q | d_in_error_i;
      if (rlast) begin
        d_out_valid_o = d_in_valid_i;
        d_in_ready_o  = d_out_ready_i;
        d_final_fire  = d_in_valid_i & d_out_ready_i;
      end else begin
        d_in_ready_o = 1'b1;
        if (d_in_valid_i) begin
          rcnt_d = rcnt_q + CNT_W'(1);
          err_d  = err_q | d_in_error_i;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          size_d  = in_size_i;
          src_d   = in_source_i;
          icnt_d  = '0;
          rcnt_d  = '0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        out_valid_o   = in_valid_i;
        in_ready_o    = out_ready_i;
        rpt_o         = ~ilast;
        out_size_o    = frag_size;
        out_address_o = frag_addr;
        if (a_fire) begin
          icnt_d = icnt_q + CNT_W'(1);
          if (ilast) state_d = d_final_fire ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (d_final_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      src_q   <= '0;
      icnt_q  <= '0;
      rcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      src_q   <= src_d;
      icnt_q  <= icnt_d;
      rcnt_q  <= rcnt_d;
      err_q   <= err_d;
    end
  end

endmodule
